// File: rtl/eth_mac_pkg.sv
// ---------------------------------------------------------------------------
// eth_mac_pkg
// Shared definitions for the Ethernet TX path: arbiter state encoding, the
// default frame length limit and the width of a port/grant index.
// ---------------------------------------------------------------------------
package eth_mac_pkg;

    // Largest frame passed through untruncated, in bytes, FCS excluded.
    localparam int MAX_BEATS_DEFAULT = 1514;

    // Width of a port index; covers up to 8 requesters.
    localparam int GRANT_W = 3;

    // Width of the beat counter and the frame statistics counters.
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

endpackage : eth_mac_pkg

// File: rtl/eth_rr_select.sv
// ---------------------------------------------------------------------------
// eth_rr_select
// Combinational round-robin picker. Searches the request mask starting at
// (last_grant + 1) mod NUM_PORTS and wrapping, returning the first hit.
//
// Ports
//   req        : in  [NUM_PORTS-1:0] eligible requesters
//   last_grant : in  [GRANT_W-1:0]   most recently served port
//   grant      : out [GRANT_W-1:0]   selected port (0 when nothing found)
//   found      : out                 at least one requester was eligible
// ---------------------------------------------------------------------------
module eth_rr_select
    import eth_mac_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GRANT_W-1:0]   last_grant,
    output logic [GRANT_W-1:0]   grant,
    output logic                 found
);

    always_comb begin
        int idx;
        // NOTE: every output and temporary gets a default before the search;
        // a path that leaves one unassigned would infer a latch.
        grant = '0;
        found = 1'b0;
        idx   = 0;
        // Offset 1 is the highest priority, offset NUM_PORTS (the last
        // granted port itself) the lowest.
        for (int off = 1; off <= NUM_PORTS; off++) begin
            idx = int'(last_grant) + off;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!found && (p == idx) && req[p]) begin
                    grant = GRANT_W'(p);
                    found = 1'b1;
                end
            end
        end
    end

endmodule : eth_rr_select

// File: rtl/eth_tx_arbiter.sv
// ---------------------------------------------------------------------------
// eth_tx_arbiter
// Round-robin arbiter merging NUM_PORTS byte-wide AXI-Stream frame sources
// into one stream toward the MAC TX. A granted frame is passed through
// combinationally; frames longer than MAX_BEATS are cut with a forced tlast
// and the rest of the source frame is drained and discarded.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   s_axis_tdata    : in  [NUM_PORTS*8-1:0] per-port byte, port i at [8i+7:8i]
//   s_axis_tvalid   : in  [NUM_PORTS-1:0]   per-port valid
//   s_axis_tlast    : in  [NUM_PORTS-1:0]   per-port end of frame
//   s_axis_tready   : out [NUM_PORTS-1:0]   per-port ready
//   m_axis_tdata    : out [7:0]             merged byte stream
//   m_axis_tvalid   : out                   merged valid
//   m_axis_tlast    : out                   merged end of frame
//   m_axis_tready   : in                    ready from MAC TX
//   port_en         : in  [NUM_PORTS-1:0]   per-port arbitration enable
//   grant_id        : out [2:0]             current / most recent grant
//   arb_busy        : out                   a frame is being passed or drained
//   tx_frame_count  : out [15:0]            frames completed normally
//   tx_trunc_count  : out [15:0]            frames truncated
// ---------------------------------------------------------------------------
module eth_tx_arbiter
    import eth_mac_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int MAX_BEATS = MAX_BEATS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_PORTS*8-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]   s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]   s_axis_tlast,
    output logic [NUM_PORTS-1:0]   s_axis_tready,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    input  logic [NUM_PORTS-1:0]   port_en,
    output logic [GRANT_W-1:0]     grant_id,
    output logic                   arb_busy,
    output logic [CNT_W-1:0]       tx_frame_count,
    output logic [CNT_W-1:0]       tx_trunc_count
);

    arb_state_e       state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   trunc_cnt_q, trunc_cnt_d;

    logic [NUM_PORTS-1:0] req;
    logic [GRANT_W-1:0]   rr_grant;
    logic                 rr_found;

    logic [NUM_PORTS-1:0] grant_onehot;
    logic [7:0]           sel_data;
    logic                 sel_valid;
    logic                 sel_last;
    logic                 at_limit;
    logic                 accept;

    // Only enabled ports with a pending beat compete.
    assign req = s_axis_tvalid & port_en;

    eth_rr_select #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_select (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (rr_grant),
        .found      (rr_found)
    );

    // Granted-port source mux, built by comparison so the grant index never
    // addresses past NUM_PORTS-1.
    always_comb begin
        grant_onehot = '0;
        sel_data     = '0;
        sel_valid    = 1'b0;
        sel_last     = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == GRANT_W'(p)) begin
                grant_onehot[p] = 1'b1;
                sel_data        = s_axis_tdata[8*p +: 8];
                sel_valid       = s_axis_tvalid[p];
                sel_last        = s_axis_tlast[p];
            end
        end
    end

    // This beat is the last one allowed for the frame.
    assign at_limit = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

    // Stream outputs: silent in idle, pass-through while transferring,
    // sink-only while draining the tail of a truncated frame.
    always_comb begin
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        unique case (state_q)
            ST_XFER: begin
                m_axis_tdata  = sel_data;
                m_axis_tvalid = sel_valid;
                m_axis_tlast  = sel_valid & (sel_last | at_limit);
                s_axis_tready = grant_onehot & {NUM_PORTS{m_axis_tready}};
            end
            ST_DRAIN: begin
                s_axis_tready = grant_onehot;
            end
            default: begin
            end
        endcase
    end

    assign accept = (state_q == ST_XFER) && sel_valid && m_axis_tready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        trunc_cnt_d  = trunc_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d    = rr_grant;
                    beat_cnt_d = '0;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (sel_last) begin
                        // Source ended the frame, even if exactly at the limit.
                        last_grant_d = grant_q;
                        frame_cnt_d  = frame_cnt_q + 1'b1;
                        state_d      = ST_IDLE;
                    end else if (at_limit) begin
                        trunc_cnt_d = trunc_cnt_q + 1'b1;
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (sel_valid && sel_last) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: last_grant resets to the highest port so the first search after
    // reset starts at port 0; all other state resets to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GRANT_W'(NUM_PORTS - 1);
            beat_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            trunc_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            trunc_cnt_q  <= trunc_cnt_d;
        end
    end

    assign grant_id       = grant_q;
    assign arb_busy       = (state_q != ST_IDLE);
    assign tx_frame_count = frame_cnt_q;
    assign tx_trunc_count = trunc_cnt_q;

endmodule : eth_tx_arbiter

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of AXI-Stream requesters, range 2..8.
REQ-002 SHALL have parameter MAX_BEATS, default 1514: maximum bytes per frame before truncation, excluding FCS.
REQ-003 SHALL have port clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port s_axis_tdata, input, NUM_PORTS*8: per-port byte; port i occupies bits [8i+7:8i].
REQ-006 SHALL have ports s_axis_tvalid and s_axis_tlast, input, NUM_PORTS each: per-port valid and end-of-frame flags.
REQ-007 SHALL have port s_axis_tready, output, NUM_PORTS: per-port ready.
REQ-008 SHALL have ports m_axis_tdata (8), m_axis_tvalid (1) and m_axis_tlast (1), all outputs: the stream toward the MAC TX.
REQ-009 SHALL have port m_axis_tready, input, 1: ready from the MAC TX.
REQ-010 SHALL have port port_en, input, NUM_PORTS: per-port arbitration enable.
REQ-011 SHALL have port grant_id, output, 3: index of the current or most recent grant.
REQ-012 SHALL have port arb_busy, output, 1: high in any state except ST_IDLE.
REQ-013 SHALL have port tx_frame_count, output, 16: count of frames completed normally.
REQ-014 SHALL have port tx_trunc_count, output, 16: count of frames truncated.

Function
REQ-015 SHALL implement states ST_IDLE, ST_XFER and ST_DRAIN.
REQ-016 In ST_IDLE, when any port i has s_axis_tvalid[i] and port_en[i] high, the block SHALL register a grant to the first eligible port searching round-robin from (last_grant+1) mod NUM_PORTS, then enter ST_XFER on the next cycle; arbitration latency is 1 cycle.
REQ-017 In ST_IDLE, all s_axis_tready bits and m_axis_tvalid SHALL be 0.
REQ-018 In ST_XFER, the block SHALL pass the granted port combinationally: m_axis_tdata, m_axis_tvalid and m_axis_tlast come from that port, s_axis_tready[grant] = m_axis_tready, and every other ready bit is 0.
REQ-019 A beat SHALL count as accepted when m_axis_tvalid and m_axis_tready are both high; a 16-bit beat counter SHALL clear on grant and increment per accepted beat.
REQ-020 When an accepted beat carries tlast in ST_XFER, the block SHALL return to ST_IDLE, set last_grant to the granted port and increment tx_frame_count.
REQ-021 When the beat counter equals MAX_BEATS-1 and the accepted beat has no source tlast, m_axis_tlast SHALL be forced to 1 on that beat, tx_trunc_count SHALL increment, and the state SHALL become ST_DRAIN.
REQ-022 In ST_DRAIN, s_axis_tready[grant] SHALL be 1 and m_axis_tvalid 0; source beats SHALL be discarded until a beat with tlast is consumed, after which the state becomes ST_IDLE and last_grant is updated.
REQ-023 Deasserting port_en of the granted port mid-frame SHALL NOT abort the frame; port_en affects only the next arbitration.
REQ-024 A single-beat frame (tvalid and tlast on the first beat) SHALL complete in ST_XFER in one cycle given m_axis_tready.
REQ-025 Both counters SHALL wrap from 0xFFFF to 0x0000.
REQ-026 grant_id SHALL hold its value in ST_IDLE until the next grant.

Reset
REQ-027 When rst_n is low, the block SHALL enter ST_IDLE and drive grant_id=0, tx_frame_count=0, tx_trunc_count=0, arb_busy=0 and the beat counter to 0.
REQ-028 When rst_n is low, last_grant SHALL be NUM_PORTS-1 so that port 0 has first priority after reset.
REQ-029 All outputs SHALL read 0 during reset, and reset asserted mid-frame SHALL abandon the frame with no count update.

Structure
REQ-030 State encodings, MAX_BEATS default and the grant-index width SHALL live in a shared package eth_mac_pkg.
REQ-031 The round-robin next-grant search SHALL be a sub-module named eth_rr_select: purely combinational, with inputs req mask and last_grant, and outputs grant index and found.

Verification
REQ-032 Ports 0..3 request simultaneously with 3-byte frames and m_axis_tready=1 -> grants in order 0,1,2,3; tx_frame_count=4; one idle cycle between frames.
REQ-033 Port 2 alone sends a 60-byte frame while m_axis_tready toggles 1/0 each cycle -> 60 bytes delivered in order, tlast only on byte 60, and s_axis_tready[2] mirroring m_axis_tready.
REQ-034 Port 1 sends 1600 bytes with MAX_BEATS=1514 -> 1514 bytes output with tlast on byte 1514, 86 bytes drained, tx_trunc_count=1, state back in ST_IDLE.
REQ-035 port_en=4'b1010 with all ports requesting -> only ports 1 and 3 are granted, alternating.
REQ-036 rst_n pulsed low during byte 10 of a port 0 frame -> all outputs 0 and counters unchanged at 0; after release with port 0 requesting, port 0 is granted first.
REQ-037 Port 3 sends a single-beat frame -> one output beat with tlast=1 and tx_frame_count incremented by 1.
